// File: rtl/dump_uart_tx.sv
// Host-side dump handshake plus 8N1 UART serializer.
// The dump controller gates dump requests on capture_done and counts acknowledged bytes.
// The serializer transmits one byte for each send_dump request, independently of the controller.
module dump_uart_tx #(
   parameter int unsigned BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dump_req,
   input  logic       capture_done,
   output logic       start_dump,
   input  logic       send_dump,
   input  logic [7:0] dump_data,
   output logic       dump_sent,
   input  logic       dump_finished,
   output logic       clr_capture_done,
   output logic       dump_rej,
   output logic       tx,
   output logic       busy,
   output logic [9:0] byte_cnt
);

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      D_IDLE,
      D_START,
      D_RUN
   } dstate_t;

   typedef enum logic [2:0] {
      T_IDLE,
      T_START,
      T_DATA,
      T_STOP,
      T_ACK
   } tstate_t;

   dstate_t     dstate, dstate_nxt;
   logic [9:0]  byte_cnt_nxt;

   tstate_t     tstate, tstate_nxt;
   logic [15:0] baud_cnt, baud_cnt_nxt;
   logic [2:0]  bit_idx, bit_idx_nxt;
   logic [7:0]  shift, shift_nxt;
   logic        tx_nxt;
   logic        baud_end;

   // ---------------------------------------------------------------
   // Dump controller
   // ---------------------------------------------------------------

   // Controller state and byte counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dstate   <= D_IDLE;
         byte_cnt <= '0;
      end else begin
         dstate   <= dstate_nxt;
         byte_cnt <= byte_cnt_nxt;
      end
   end

   // Controller next state, byte counting and handshake pulses
   always_comb begin
      dstate_nxt       = dstate;
      byte_cnt_nxt     = byte_cnt;
      start_dump       = 1'b0;
      clr_capture_done = 1'b0;
      dump_rej         = 1'b0;
      unique case (dstate)
         D_IDLE: begin
            if (dump_req) begin
               if (capture_done) begin
                  dstate_nxt = D_START;
               end else begin
                  dump_rej = 1'b1;
               end
            end
         end
         D_START: begin
            start_dump   = 1'b1;
            dump_rej     = dump_req;
            byte_cnt_nxt = '0;
            dstate_nxt   = D_RUN;
         end
         D_RUN: begin
            dump_rej = dump_req;
            // the last ack arrives together with dump_finished and still counts
            if (dump_sent && (byte_cnt != '1)) begin
               byte_cnt_nxt = byte_cnt + 10'd1;
            end
            if (dump_finished) begin
               clr_capture_done = 1'b1;
               dstate_nxt       = D_IDLE;
            end
         end
         default: dstate_nxt = D_IDLE;
      endcase
   end

   assign busy = (dstate != D_IDLE);

   // ---------------------------------------------------------------
   // UART serializer
   // ---------------------------------------------------------------

   assign baud_end = (baud_cnt == BAUD_LAST);

   // Serializer state and datapath registers; tx idles high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tstate   <= T_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         tstate   <= tstate_nxt;
         baud_cnt <= baud_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shift    <= shift_nxt;
         tx       <= tx_nxt;
      end
   end

   // Serializer next state: start bit, 8 data bits LSB first, stop bit, then ack
   always_comb begin
      tstate_nxt   = tstate;
      baud_cnt_nxt = baud_cnt;
      bit_idx_nxt  = bit_idx;
      shift_nxt    = shift;
      tx_nxt       = tx;
      dump_sent    = 1'b0;
      unique case (tstate)
         T_IDLE: begin
            tx_nxt = 1'b1;
            if (send_dump) begin
               shift_nxt    = dump_data;
               baud_cnt_nxt = '0;
               bit_idx_nxt  = '0;
               tx_nxt       = 1'b0;
               tstate_nxt   = T_START;
            end
         end
         T_START: begin
            if (baud_end) begin
               baud_cnt_nxt = '0;
               tx_nxt       = shift[0];
               tstate_nxt   = T_DATA;
            end else begin
               baud_cnt_nxt = baud_cnt + 16'd1;
            end
         end
         T_DATA: begin
            if (baud_end) begin
               baud_cnt_nxt = '0;
               shift_nxt    = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  tx_nxt     = 1'b1;
                  tstate_nxt = T_STOP;
               end else begin
                  // tx is registered, so it takes the bit that shifts into position 0
                  tx_nxt      = shift[1];
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end else begin
               baud_cnt_nxt = baud_cnt + 16'd1;
            end
         end
         T_STOP: begin
            if (baud_end) begin
               baud_cnt_nxt = '0;
               tstate_nxt   = T_ACK;
            end else begin
               baud_cnt_nxt = baud_cnt + 16'd1;
            end
         end
         T_ACK: begin
            dump_sent  = 1'b1;
            tstate_nxt = T_IDLE;
         end
         default: tstate_nxt = T_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dump_uart_tx.sv
// Bench for dump_uart_tx: directed stimulus with a UART scoreboard monitor.
module tb_dump_uart_tx;

   localparam int unsigned BAUD = 4;

   logic       clk           = 1'b0;
   logic       rst_n         = 1'b0;
   logic       dump_req      = 1'b0;
   logic       capture_done  = 1'b0;
   logic       send_dump     = 1'b0;
   logic       dump_finished = 1'b0;
   logic [7:0] dump_data     = '0;
   logic       start_dump, dump_sent, clr_capture_done, dump_rej, tx, busy;
   logic [9:0] byte_cnt;

   int         n_checks    = 0;
   int         n_fail      = 0;
   int         sent_pulses = 0;
   int         pulses0;
   logic [7:0] exp_q[$];

   dump_uart_tx #(.BAUD_DIV(BAUD)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .dump_req         (dump_req),
      .capture_done     (capture_done),
      .start_dump       (start_dump),
      .send_dump        (send_dump),
      .dump_data        (dump_data),
      .dump_sent        (dump_sent),
      .dump_finished    (dump_finished),
      .clr_capture_done (clr_capture_done),
      .dump_rej         (dump_rej),
      .tx               (tx),
      .busy             (busy),
      .byte_cnt         (byte_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: decodes every tx frame against the expected byte queue
   logic       mon_active = 1'b0;
   logic       mon_quiet  = 1'b0;
   logic       prev_tx    = 1'b1;
   int         mon_n      = 0;
   logic [7:0] mon_exp    = '0;
   logic [7:0] mon_dec    = '0;
   logic [9:0] mon_frame  = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_active = 1'b0;
         mon_quiet  = 1'b0;
         prev_tx    = 1'b1;
      end else begin
         if (dump_sent) sent_pulses++;
         if (mon_quiet) begin
            check("dump_sent one cycle only", 32'(dump_sent), 0);
            mon_quiet = 1'b0;
         end
         if (!mon_active && prev_tx && !tx) begin
            check("frame expected at start bit", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               mon_exp    = exp_q.pop_front();
               mon_frame  = {1'b1, mon_exp, 1'b0};
               mon_dec    = '0;
               mon_n      = 0;
               mon_active = 1'b1;
            end
         end
         if (mon_active) begin
            if (mon_n < 40) begin
               check("tx frame bit", 32'(tx), 32'(mon_frame[mon_n / 4]));
               check("dump_sent before frame end", 32'(dump_sent), 0);
               if ((mon_n % 4 == 2) && (mon_n / 4 >= 1) && (mon_n / 4 <= 8))
                  mon_dec[mon_n / 4 - 1] = tx;
            end else begin
               check("dump_sent at E0+41", 32'(dump_sent), 1);
               check("decoded byte", 32'(mon_dec), 32'(mon_exp));
               mon_active = 1'b0;
               mon_quiet  = 1'b1;
            end
            mon_n++;
         end
         prev_tx = tx;
      end
   end

   // Capture engine side of one byte transfer; dump_finished rides the final ack
   task automatic send_byte(input logic [7:0] b, input logic last);
      int unsigned k;
      @(posedge clk); #1;
      send_dump = 1'b1;
      dump_data = b;
      exp_q.push_back(b);
      @(posedge clk); #1;
      dump_data = ~b;
      k = 0;
      @(negedge clk);
      while (!dump_sent && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("dump_sent arrives", 32'(dump_sent), 1);
      if (last) begin
         dump_finished = 1'b1;
         #1;
         check("clr_capture_done with final ack", 32'(clr_capture_done), 1);
      end
      @(posedge clk); #1;
      send_dump     = 1'b0;
      dump_finished = 1'b0;
   endtask

   task automatic start_new_dump();
      @(posedge clk); #1;
      capture_done = 1'b1;
      dump_req     = 1'b1;
      @(posedge clk); #1;
      dump_req = 1'b0;
      @(negedge clk);
      check("start_dump after request", 32'(start_dump), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " tx"},               32'(tx), 1);
      check({tag, " start_dump"},       32'(start_dump), 0);
      check({tag, " dump_sent"},        32'(dump_sent), 0);
      check({tag, " clr_capture_done"}, 32'(clr_capture_done), 0);
      check({tag, " dump_rej"},         32'(dump_rej), 0);
      check({tag, " busy"},             32'(busy), 0);
      check({tag, " byte_cnt"},         32'(byte_cnt), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // request without a completed capture is rejected
      @(posedge clk); #1;
      capture_done = 1'b0;
      dump_req     = 1'b1;
      @(negedge clk);
      check("dump_rej without capture", 32'(dump_rej), 1);
      @(posedge clk); #1;
      dump_req = 1'b0;
      @(negedge clk);
      check("no start_dump on reject", 32'(start_dump), 0);
      check("idle after reject", 32'(busy), 0);
      check("dump_rej single cycle", 32'(dump_rej), 0);

      // accepted request: start_dump one cycle, one cycle after the request
      @(posedge clk); #1;
      capture_done = 1'b1;
      dump_req     = 1'b1;
      @(negedge clk);
      check("start_dump not same cycle", 32'(start_dump), 0);
      check("no reject with capture", 32'(dump_rej), 0);
      @(posedge clk); #1;
      dump_req = 1'b0;
      @(negedge clk);
      check("start_dump pulse", 32'(start_dump), 1);
      check("busy in dump", 32'(busy), 1);
      @(negedge clk);
      check("start_dump one cycle", 32'(start_dump), 0);
      check("byte_cnt cleared", 32'(byte_cnt), 0);

      send_byte(8'hA5, 1'b0);
      check("byte_cnt after A5", 32'(byte_cnt), 1);

      // request during a running dump is rejected and does not disturb the count
      @(posedge clk); #1;
      dump_req = 1'b1;
      @(negedge clk);
      check("dump_rej during run", 32'(dump_rej), 1);
      check("no start_dump during run", 32'(start_dump), 0);
      @(posedge clk); #1;
      dump_req = 1'b0;
      @(negedge clk);
      check("byte_cnt after run reject", 32'(byte_cnt), 1);
      check("still busy", 32'(busy), 1);

      send_byte(8'h81, 1'b1);
      check("busy drops after finish", 32'(busy), 0);
      check("byte_cnt dump 1", 32'(byte_cnt), 2);
      capture_done = 1'b0;

      // three-byte dump, final ack coincides with dump_finished
      start_new_dump();
      send_byte(8'h00, 1'b0);
      send_byte(8'hFF, 1'b0);
      send_byte(8'h3C, 1'b1);
      check("byte_cnt dump 2", 32'(byte_cnt), 3);
      check("busy drops after dump 2", 32'(busy), 0);
      capture_done = 1'b0;

      // send_dump still high during the ack cycle must not start a second frame
      pulses0 = sent_pulses;
      send_byte(8'h96, 1'b0);
      repeat (30) @(negedge clk);
      check("single ack for held send_dump", 32'(sent_pulses - pulses0), 1);
      check("tx idle after single frame", 32'(tx), 1);
      check("byte_cnt kept while idle", 32'(byte_cnt), 3);

      // reset in the middle of data bit 3
      start_new_dump();
      send_byte(8'h11, 1'b0);
      check("byte_cnt before abort", 32'(byte_cnt), 1);
      pulses0 = sent_pulses;
      @(posedge clk); #1;
      send_dump = 1'b1;
      dump_data = 8'hC3;
      exp_q.push_back(8'hC3);
      @(posedge clk);
      repeat (17) @(posedge clk);
      #2;
      check("tx carries bit 3 of C3", 32'(tx), 0);
      rst_n     = 1'b0;
      send_dump = 1'b0;
      #1;
      check_reset_outputs("async reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check("no ack after abort", 32'(sent_pulses - pulses0), 0);
      check("tx idle after abort", 32'(tx), 1);
      check("expected queue drained", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dump_uart_tx.md
# dump_uart_tx

Host-side end of the capture dump handshake. It starts a dump on a host request once a capture is complete. For each byte the capture engine presents via `send_dump`, it serializes the RAM read data as a UART 8N1 frame and acknowledges with a single-cycle `dump_sent`. When the capture engine reports `dump_finished`, it clears the capture-done flag so the next capture can arm.

## Interface
Parameters:
- BAUD_DIV, 434, clk cycles per UART bit period (legal range 2..65535).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- dump_req  in  1  host command pulse requesting a dump
- capture_done  in  1  capture complete flag; level
- start_dump  out  1  one-cycle pulse to capture engine to begin dump
- send_dump  in  1  capture engine: dump_data valid, byte awaiting transmission (held until dump_sent)
- dump_data  in  8  RAM read data, valid whenever send_dump=1
- dump_sent  out  1  one-cycle acknowledge: byte fully transmitted
- dump_finished  in  1  capture engine: last byte acknowledged; one cycle
- clr_capture_done  out  1  one-cycle pulse clearing capture_done
- dump_rej  out  1  one-cycle pulse: dump_req ignored
- tx  out  1  UART serial output, idle high
- busy  out  1  dump in progress (controller not in D_IDLE)
- byte_cnt  out  10  bytes acknowledged in current/last dump

## Operation
Dump controller FSM: D_IDLE, D_START, D_RUN.
- D_IDLE: dump_req & capture_done -> D_START. dump_req & !capture_done -> dump_rej pulse, stay.
- D_START: start_dump=1 (Moore, exactly one cycle); byte_cnt <= 0; -> D_RUN.
- D_RUN: dump_req -> dump_rej pulse, ignored. dump_sent -> byte_cnt+1, saturating at 1023. dump_finished -> clr_capture_done=1 in the same cycle; next state D_IDLE.
- dump_finished coincides with the final dump_sent (same cycle). That final byte must be counted.
- busy = (state != D_IDLE).

Serializer FSM: T_IDLE, T_START, T_DATA, T_STOP, T_ACK.
- Shared baud counter: 16 bits, counts 0..BAUD_DIV-1. Bit index: 3 bits.
- T_IDLE: send_dump=1 -> latch dump_data into shift register; clear baud counter; -> T_START.
- T_START: tx=0 for BAUD_DIV cycles -> T_DATA.
- T_DATA: tx=shift[0], LSB first. Each bit lasts BAUD_DIV cycles, then shift right. After bit 7 -> T_STOP.
- T_STOP: tx=1 for BAUD_DIV cycles -> T_ACK.
- T_ACK: dump_sent=1 (Moore, one cycle); -> T_IDLE unconditionally.
- send_dump is sampled only in T_IDLE. Its being still high during T_ACK is legal and must not relatch.
- The serializer operates independently of the controller state. Bytes are sent whenever send_dump appears.

Reset values: start_dump=0, dump_sent=0, clr_capture_done=0, dump_rej=0, tx=1, busy=0, byte_cnt=0. Both FSMs reset to idle, shift register to 0.

## Timing
- tx is registered. The frame edge (tx 1->0) appears on the clk edge that samples send_dump=1 in T_IDLE (edge E0).
- Frame occupies E0 .. E0+10*BAUD_DIV. dump_sent is high for the cycle following E0+10*BAUD_DIV.
- Back-to-back bytes: T_IDLE needs at least one cycle between T_ACK and the next frame. Minimum byte period is 10*BAUD_DIV+2 cycles.
- dump_req -> start_dump latency: start_dump is high for the cycle after the edge sampling dump_req.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronous). No dump_sent is generated. Any partial frame is abandoned.
- dump_data must be stable only on the sampling edge E0.

## Test plan
- BAUD_DIV=4, capture_done=1, dump_req pulse -> start_dump high exactly one cycle, the cycle after dump_req; busy=1.
- send_dump=1 with dump_data=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. dump_sent pulses once at E0+41 cycles; byte 0xA5 decoded by the bench UART model.
- Three bytes 0x00, 0xFF, 0x3C, with the final dump_sent coinciding with dump_finished -> byte_cnt=3. clr_capture_done pulses in the same cycle; busy drops the next cycle.
- dump_req with capture_done=0 -> dump_rej one cycle, no start_dump. dump_req again during D_RUN -> dump_rej, byte_cnt unaffected.
- send_dump held high through T_ACK, falling the cycle after dump_sent -> exactly one frame transmitted, no second frame.
- rst_n low during bit 3 of a frame -> tx=1 immediately. All outputs return to reset values. No dump_sent occurs after release.
